bp_be_fpu_result_collector: RTL and testbench

- Sits directly downstream of the fixed-latency hardfloat FPU.
- FPU has no stall: results emerge exactly latency_p-1 cycles after operands are presented, whether or not anyone is ready.
- This block shadows each issued op's destination register through the FPU pipe, captures result and exception flags into a credit-protected FIFO, and presents them to writeback with a valid/yumi handshake.
- Also owns the sticky fflags accumulator read by the CSR file.

---
 rtl/bp_be_fpu_result_collector.sv | 174 +++++++++++++++++
 tb/tb_bp_be_fpu_result_collector.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_fpu_result_collector.sv
// ---------------------------------------------------------------------------
// bp_be_fpu_result_collector
//
// Collects results from a fixed-latency, non-stalling FPU. Each issued op's
// destination register travels through a shadow pipe alongside the FPU. When
// the op reaches the tail, its result and exception flags go into an in-order
// FIFO. Writeback takes entries from the FIFO with a valid/yumi handshake.
// A credit counter (ops in flight plus ops queued) limits issue so that every
// result has a FIFO slot waiting for it. The block also holds the sticky
// fflags accumulator that the CSR file reads and writes.
//
// Optional feature macro: BP_BE_FPU_COLLECTOR_BYPASS_EN
//   When defined, a result that arrives while the FIFO is empty is shown on
//   wb_* in the same cycle. If it is consumed in that cycle it is never
//   written into the FIFO.
//
// Ports:
//   clk_i, reset_i      clock; synchronous active-high reset
//   issue_v_i/_rd_i     op issued to the FPU and its destination register
//   issue_ready_o       a credit is free (derived from registered state only)
//   flush_i             kill every op still inside the FPU pipe
//   fpu_data_i/_eflags_i FPU result and flags, aligned with the tail stage
//   wb_v_o/_rd_o/_data_o/_eflags_o  head of the result queue
//   wb_yumi_i           writeback consumes the head entry
//   fflags_o            sticky accumulated flags
//   fflags_w_v_i/_w_i   CSR write of fflags
// ---------------------------------------------------------------------------
module bp_be_fpu_result_collector #(
  parameter int unsigned latency_p        = 5,
  parameter int unsigned fifo_els_p       = 4,
  parameter int unsigned reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        issue_v_i,
  input  logic [reg_addr_width_p-1:0] issue_rd_i,
  output logic                        issue_ready_o,
  input  logic                        flush_i,
  input  logic [63:0]                 fpu_data_i,
  input  logic [4:0]                  fpu_eflags_i,
  output logic                        wb_v_o,
  output logic [reg_addr_width_p-1:0] wb_rd_o,
  output logic [63:0]                 wb_data_o,
  output logic [4:0]                  wb_eflags_o,
  input  logic                        wb_yumi_i,
  output logic [4:0]                  fflags_o,
  input  logic                        fflags_w_v_i,
  input  logic [4:0]                  fflags_w_i
);

  localparam int unsigned StagesLp = latency_p - 1;
  localparam int unsigned CntW     = $clog2(fifo_els_p + 1);
  localparam int unsigned PtrW     = $clog2(fifo_els_p);
  localparam int unsigned DataW    = 64;
  localparam int unsigned FlagW    = 5;

  // Shadow pipe: valid bits and destination registers
  logic [StagesLp-1:0]         sv_q, sv_d;
  logic [reg_addr_width_p-1:0] srd_q [StagesLp];
  logic [reg_addr_width_p-1:0] srd_d [StagesLp];

  // Credits, FIFO bookkeeping, and sticky flags
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  occ_q, occ_d;
  logic [CntW-1:0]  flush_dec;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [FlagW-1:0] fflags_q, fflags_d;

  // FIFO storage
  logic [reg_addr_width_p-1:0] mem_rd_q   [fifo_els_p];
  logic [DataW-1:0]            mem_data_q [fifo_els_p];
  logic [FlagW-1:0]            mem_ef_q   [fifo_els_p];

  logic                        issue_acc;
  logic                        tail_v;
  logic [reg_addr_width_p-1:0] tail_rd;
  logic                        fifo_empty;
  logic                        enq;
  logic                        deq;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(fifo_els_p - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign issue_ready_o = (cnt_q < CntW'(fifo_els_p));
  // A flush also drops an issue made in the same cycle.
  assign issue_acc     = issue_v_i & issue_ready_o & ~flush_i;
  // A flush kills the tail too, so that cycle's FPU result is discarded.
  assign tail_v        = sv_q[StagesLp-1] & ~flush_i;
  assign tail_rd       = srd_q[StagesLp-1];
  assign fifo_empty    = (occ_q == '0);
  assign deq           = wb_yumi_i & ~fifo_empty;
  assign fflags_o      = fflags_q;

`ifdef BP_BE_FPU_COLLECTOR_BYPASS_EN
  // Show a fresh arrival directly when nothing is queued ahead of it.
  logic bypass;
  assign bypass      = fifo_empty & tail_v;
  assign wb_v_o      = ~fifo_empty | tail_v;
  assign wb_rd_o     = bypass ? tail_rd      : mem_rd_q[rptr_q];
  assign wb_data_o   = bypass ? fpu_data_i   : mem_data_q[rptr_q];
  assign wb_eflags_o = bypass ? fpu_eflags_i : mem_ef_q[rptr_q];
  assign enq         = tail_v & ~(bypass & wb_yumi_i);
`else
  assign wb_v_o      = ~fifo_empty;
  assign wb_rd_o     = mem_rd_q[rptr_q];
  assign wb_data_o   = mem_data_q[rptr_q];
  assign wb_eflags_o = mem_ef_q[rptr_q];
  assign enq         = tail_v;
`endif

  // Next-state logic
  always_comb begin
    sv_d      = '0;
    flush_dec = '0;
    for (int unsigned i = 0; i < StagesLp; i++) begin
      srd_d[i] = srd_q[i];
    end

    sv_d[0]  = issue_acc;
    srd_d[0] = issue_rd_i;
    for (int unsigned i = 1; i < StagesLp; i++) begin
      sv_d[i]  = sv_q[i-1] & ~flush_i;
      srd_d[i] = srd_q[i-1];
    end

    // Every valid stage, the tail included, gives back its credit on flush.
    for (int unsigned i = 0; i < StagesLp; i++) begin
      flush_dec = flush_dec + CntW'(sv_q[i]);
    end

    cnt_d = cnt_q + CntW'(issue_acc) - CntW'(wb_yumi_i)
          - (flush_i ? flush_dec : CntW'(0));
    occ_d = occ_q + CntW'(enq) - CntW'(deq);

    wptr_d = enq ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = deq ? ptr_inc(rptr_q) : rptr_q;

    // A CSR write and a retiring op's flags can both land in the same cycle.
    fflags_d = (fflags_w_v_i ? fflags_w_i : fflags_q)
             | (wb_yumi_i ? wb_eflags_o : FlagW'(0));
  end

  // Control state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sv_q     <= '0;
      cnt_q    <= '0;
      occ_q    <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      fflags_q <= '0;
    end else begin
      sv_q     <= sv_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      fflags_q <= fflags_d;
    end
  end

  // Datapath storage; its contents only matter while the matching valid is set.
  always_ff @(posedge clk_i) begin
    srd_q <= srd_d;
    if (enq) begin
      mem_rd_q[wptr_q]   <= tail_rd;
      mem_data_q[wptr_q] <= fpu_data_i;
      mem_ef_q[wptr_q]   <= fpu_eflags_i;
    end
  end

endmodule

// File: tb/tb_bp_be_fpu_result_collector.sv
// ---------------------------------------------------------------------------
// tb_bp_be_fpu_result_collector
//
// Testbench for bp_be_fpu_result_collector with the default parameters. It
// runs a table of per-cycle vectors for the basic flows, hand-written
// sequences for flush, FIFO pointer wrap and reset, and then random
// traffic. All runs are checked against a queue-based model of in-flight
// ops and queued results.
// Optional macro BP_BE_FPU_COLLECTOR_BYPASS_EN selects the bypass timing.
// ---------------------------------------------------------------------------
module tb_bp_be_fpu_result_collector;

  localparam int LAT    = 5;
  localparam int FIFO_N = 4;
`ifdef BP_BE_FPU_COLLECTOR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i, issue_v_i, issue_ready_o, flush_i;
  logic [4:0]  issue_rd_i, fpu_eflags_i, wb_rd_o, wb_eflags_o, fflags_o, fflags_w_i;
  logic [63:0] fpu_data_i, wb_data_o;
  logic        wb_v_o, wb_yumi_i, fflags_w_v_i;

  always #5 clk = ~clk;

  bp_be_fpu_result_collector dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .issue_v_i    (issue_v_i),
    .issue_rd_i   (issue_rd_i),
    .issue_ready_o(issue_ready_o),
    .flush_i      (flush_i),
    .fpu_data_i   (fpu_data_i),
    .fpu_eflags_i (fpu_eflags_i),
    .wb_v_o       (wb_v_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o),
    .wb_eflags_o  (wb_eflags_o),
    .wb_yumi_i    (wb_yumi_i),
    .fflags_o     (fflags_o),
    .fflags_w_v_i (fflags_w_v_i),
    .fflags_w_i   (fflags_w_i)
  );

  typedef struct {
    logic        rst, iv, fl, yumi, fwv;
    logic [4:0]  rd, ef, fw;
    logic [63:0] data;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_ready, e_v;
    logic [4:0]  e_rd, e_ef, e_ff;
    logic [63:0] e_data;
  } vec_t;

  typedef struct { logic [4:0] rd; int arrive; } fl_t;
  typedef struct { logic [4:0] rd; logic [63:0] data; logic [4:0] ef; } ent_t;

  // Reference model: ops in flight with their arrival cycle, and queued results
  fl_t        pipe[$];
  ent_t       fifo[$];
  logic [4:0] m_ff;
  int         cyc;
  stim_t      cur;
  logic       m_arr, m_v, m_ready, yumi_eff, iss_eff;
  ent_t       m_head;
  int         n_chk = 0;
  int         n_err = 0;
  int         n_iss, n_ret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rst = 0; s.iv = 0; s.fl = 0; s.yumi = 0; s.fwv = 0;
    s.rd = 5'($urandom); s.fw = 5'($urandom);
    s.ef = 5'($urandom); s.data = {$urandom, $urandom};
    return s;
  endfunction

  // Apply one cycle of inputs and work out what the model expects this cycle.
  task automatic drive(input stim_t s);
    cur = s;
    m_arr   = !s.fl && pipe.size() > 0 && pipe[0].arrive == cyc;
    m_v     = fifo.size() > 0 || (BYP && m_arr);
    m_ready = (pipe.size() + fifo.size()) < FIFO_N;
    if (fifo.size() > 0) m_head = fifo[0];
    else begin
      m_head.rd   = m_arr ? pipe[0].rd : 5'd0;
      m_head.data = s.data;
      m_head.ef   = s.ef;
    end
    yumi_eff = s.yumi && m_v;
    iss_eff  = s.iv && m_ready && !s.fl && !s.rst;
    reset_i = s.rst; issue_v_i = s.iv; issue_rd_i = s.rd; flush_i = s.fl;
    fpu_data_i = s.data; fpu_eflags_i = s.ef; wb_yumi_i = yumi_eff;
    fflags_w_v_i = s.fwv; fflags_w_i = s.fw;
    #1;
  endtask

  task automatic check_model();
    chk("ready", 64'(issue_ready_o), 64'(m_ready));
    chk("wb_v", 64'(wb_v_o), 64'(m_v));
    if (m_v) begin
      chk("wb_rd", 64'(wb_rd_o), 64'(m_head.rd));
      chk("wb_data", wb_data_o, m_head.data);
      chk("wb_eflags", 64'(wb_eflags_o), 64'(m_head.ef));
    end
    chk("fflags", 64'(fflags_o), 64'(m_ff));
  endtask

  // Advance the model by the current cycle's inputs and move to the next cycle.
  task automatic commit();
    bit   byp_taken;
    ent_t e;
    fl_t  f;
    if (cur.rst) begin
      pipe.delete(); fifo.delete(); m_ff = '0;
    end else begin
      byp_taken = BYP && fifo.size() == 0 && m_arr && yumi_eff;
      m_ff = (cur.fwv ? cur.fw : m_ff) | (yumi_eff ? m_head.ef : 5'd0);
      if (yumi_eff) n_ret++;
      if (yumi_eff && fifo.size() > 0) void'(fifo.pop_front());
      if (m_arr && !byp_taken) begin
        e.rd = pipe[0].rd; e.data = cur.data; e.ef = cur.ef;
        fifo.push_back(e);
      end
      if (cur.fl) pipe.delete();
      else if (m_arr) void'(pipe.pop_front());
      if (iss_eff) begin
        f.rd = cur.rd; f.arrive = cyc + LAT - 1;
        pipe.push_back(f);
        n_iss++;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input stim_t s);
    drive(s);
    check_model();
    commit();
  endtask

  function automatic vec_t mk(input logic iv, input logic [4:0] rd, input logic [63:0] data,
                              input logic [4:0] ef, input logic yumi, input logic fwv,
                              input logic [4:0] fw, input logic er, input logic ev,
                              input logic [4:0] erd, input logic [63:0] edata,
                              input logic [4:0] eef, input logic [4:0] eff);
    vec_t v;
    v.s.rst = 0; v.s.fl = 0; v.s.iv = iv; v.s.rd = rd; v.s.data = data; v.s.ef = ef;
    v.s.yumi = yumi; v.s.fwv = fwv; v.s.fw = fw;
    v.e_ready = er; v.e_v = ev; v.e_rd = erd; v.e_data = edata; v.e_ef = eef; v.e_ff = eff;
    return v;
  endfunction

  vec_t  tab[$];
  stim_t s;

  initial begin
    cyc = 0; m_ff = '0; n_iss = 0; n_ret = 0;
    reset_i = 1; issue_v_i = 0; issue_rd_i = 0; flush_i = 0; fpu_data_i = 0;
    fpu_eflags_i = 0; wb_yumi_i = 0; fflags_w_v_i = 0; fflags_w_i = 0;
    repeat (2) @(posedge clk);
    #1;

    // Per-cycle vectors: single op latency, credit exhaustion, fflags merge
    //            iv rd  data                    ef        yu fwv fw        rdy v  rd  data                    ef        ff
    tab.push_back(mk(1, 3, 64'h0,                 5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00000));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00000));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00000));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00000));
    tab.push_back(mk(0, 0, 64'h4000_0000_0000_0000, 5'b00001, 0, 0, 5'b00000, 1, 0, 0, 64'h0,                5'b00000, 5'b00000));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 1, 0, 5'b00000, 1, 1, 3,  64'h4000_0000_0000_0000, 5'b00001, 5'b00000));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00001));
    tab.push_back(mk(1, 10, 64'h0,                5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00001));
    tab.push_back(mk(1, 11, 64'h0,                5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00001));
    tab.push_back(mk(1, 12, 64'h0,                5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00001));
    tab.push_back(mk(1, 13, 64'h0,                5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00001));
    tab.push_back(mk(1, 14, 64'd10,               5'b00000, 0, 0, 5'b00000, 0, 0, 0,  64'h0,                 5'b00000, 5'b00001));
    tab.push_back(mk(1, 15, 64'd11,               5'b00000, 0, 0, 5'b00000, 0, 1, 10, 64'd10,                5'b00000, 5'b00001));
    tab.push_back(mk(1, 16, 64'd12,               5'b00000, 1, 0, 5'b00000, 0, 1, 10, 64'd10,                5'b00000, 5'b00001));
    tab.push_back(mk(0, 0, 64'd13,                5'b00000, 1, 0, 5'b00000, 1, 1, 11, 64'd11,                5'b00000, 5'b00001));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 1, 0, 5'b00000, 1, 1, 12, 64'd12,                5'b00000, 5'b00001));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 1, 0, 5'b00000, 1, 1, 13, 64'd13,                5'b00000, 5'b00001));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 0, 1, 5'b10000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00001));
    tab.push_back(mk(1, 7, 64'h0,                 5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b10000));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b10000));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b10000));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b10000));
    tab.push_back(mk(0, 0, 64'hDEAD_BEEF_0000_0007, 5'b00100, 0, 0, 5'b00000, 1, 0, 0, 64'h0,                5'b00000, 5'b10000));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 1, 1, 5'b00000, 1, 1, 7,  64'hDEAD_BEEF_0000_0007, 5'b00100, 5'b10000));
    tab.push_back(mk(0, 0, 64'h0,                 5'b00000, 0, 0, 5'b00000, 1, 0, 0,  64'h0,                 5'b00000, 5'b00100));

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].s);
      check_model();
`ifndef BP_BE_FPU_COLLECTOR_BYPASS_EN
      chk($sformatf("tab%0d_ready", i), 64'(issue_ready_o), 64'(tab[i].e_ready));
      chk($sformatf("tab%0d_wb_v", i), 64'(wb_v_o), 64'(tab[i].e_v));
      if (tab[i].e_v) begin
        chk($sformatf("tab%0d_wb_rd", i), 64'(wb_rd_o), 64'(tab[i].e_rd));
        chk($sformatf("tab%0d_wb_data", i), wb_data_o, tab[i].e_data);
        chk($sformatf("tab%0d_wb_eflags", i), 64'(wb_eflags_o), 64'(tab[i].e_ef));
      end
      chk($sformatf("tab%0d_fflags", i), 64'(fflags_o), 64'(tab[i].e_ff));
`endif
      commit();
    end

    // Flush with three ops in flight: none reach writeback, credits come back
    for (int i = 1; i <= 3; i++) begin
      s = rnd_stim(); s.iv = 1; s.rd = 5'(i); run(s);
    end
    s = rnd_stim(); s.fl = 1; run(s);
    for (int i = 0; i < 8; i++) begin
      s = rnd_stim(); drive(s); check_model();
      chk("flush_no_wb", 64'(wb_v_o), 64'd0);
      chk("flush_ready", 64'(issue_ready_o), 64'd1);
      chk("flush_fflags", 64'(fflags_o), 64'(5'b00100));
      commit();
    end

    // Flush in the exact cycle the result arrives: result and flags dropped
    s = rnd_stim(); s.iv = 1; s.rd = 9; run(s);
    repeat (3) begin s = rnd_stim(); run(s); end
    s = rnd_stim(); s.fl = 1; s.ef = 5'b11111; run(s);
    for (int i = 0; i < 4; i++) begin
      s = rnd_stim(); drive(s); check_model();
      chk("tailflush_no_wb", 64'(wb_v_o), 64'd0);
      chk("tailflush_fflags", 64'(fflags_o), 64'(5'b00100));
      commit();
    end

    // Fill the FIFO, then drain 12 ops in order with a new issue each cycle
    for (int i = 0; i < FIFO_N; i++) begin
      s = rnd_stim(); s.iv = 1; run(s);
    end
    repeat (LAT) begin s = rnd_stim(); run(s); end
    chk("full_ready", 64'(issue_ready_o), 64'd0);
    n_iss = 0; n_ret = 0;
    for (int i = 0; i < 200 && n_ret < 12 + FIFO_N; i++) begin
      s = rnd_stim(); s.iv = (n_iss < 12); s.yumi = 1; run(s);
    end
    chk("wrap_drained", 64'(n_ret), 64'(12 + FIFO_N));

    // Reset with two ops queued and two in flight
    s = rnd_stim(); s.iv = 1; s.rd = 20; s.fwv = 1; s.fw = 5'b11111; run(s);
    s = rnd_stim(); s.iv = 1; s.rd = 21; run(s);
    repeat (2) begin s = rnd_stim(); run(s); end
    s = rnd_stim(); s.iv = 1; s.rd = 22; run(s);
    s = rnd_stim(); s.iv = 1; s.rd = 23; run(s);
    chk("pre_reset_queued", 64'(fifo.size()), 64'd2);
    s = rnd_stim(); s.rst = 1; run(s);
    chk("rst_wb_v", 64'(wb_v_o), 64'd0);
    chk("rst_ready", 64'(issue_ready_o), 64'd1);
    chk("rst_fflags", 64'(fflags_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      s = rnd_stim(); drive(s); check_model();
      chk("rst_stale_tail", 64'(wb_v_o), 64'd0);
      commit();
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s = rnd_stim();
      s.iv   = ($urandom_range(0, 9) < 7);
      s.fl   = ($urandom_range(0, 19) == 0);
      s.yumi = ($urandom_range(0, 9) < 6);
      s.fwv  = ($urandom_range(0, 19) == 0);
      s.rst  = ($urandom_range(0, 499) == 0);
      run(s);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
